// File: rtl/dac_auto_scaler.sv
// Automatic DAC headroom tracker: delays samples two cycles and emits a left-shift
// amount that never overflows the aligned sample (fast attack, slow windowed decay).
module dac_auto_scaler #(
    parameter int unsigned WINDOW_LOG2 = 12,
    parameter int unsigned MAX_DIST    = 14,
    parameter int unsigned HEADROOM    = 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic signed [27:0] DATA_IN,
    input  logic               DATA_VALID,
    input  logic               hold,
    output logic signed [27:0] DATA_OUT,
    output logic               DATA_VALID_OUT,
    output logic [7:0]         distance
);

    localparam int unsigned DW    = 28;
    localparam int unsigned LZW   = 5;
    localparam int unsigned DISTW = 8;
    localparam logic [LZW-1:0] LZ_MAX = LZW'(27);

    // Redundant sign bits below the MSB.
    function automatic logic [LZW-1:0] f_lz(input logic [DW-1:0] x);
        logic [LZW-1:0] cnt;
        logic           done;
        cnt  = '0;
        done = 1'b0;
        for (int i = DW - 2; i >= 0; i--) begin
            if (!done && (x[i] == x[DW-1])) begin
                cnt = cnt + LZW'(1);
            end else begin
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Reserve headroom, floor at zero, cap at MAX_DIST.
    function automatic logic [DISTW-1:0] f_clampd(input logic [LZW-1:0] v);
        int unsigned t;
        t = (32'(v) > HEADROOM) ? (32'(v) - HEADROOM) : 32'd0;
        if (t > MAX_DIST) begin
            t = MAX_DIST;
        end
        return DISTW'(t);
    endfunction

    logic signed [DW-1:0]    r_s1_data;
    logic                    r_s1_valid;
    logic [LZW-1:0]          r_s1_lz;
    logic [WINDOW_LOG2-1:0]  r_win_cnt;
    logic [LZW-1:0]          r_min_lz;

    logic [DISTW-1:0]        w_attack_amt;
    logic [DISTW-1:0]        w_decay_tgt;
    logic [LZW-1:0]          w_win_min;
    logic                    w_win_end;
    logic                    w_attack;
    logic                    w_decay;

    always_comb begin
        w_attack_amt = f_clampd(r_s1_lz);
        w_win_end    = (r_win_cnt == '1);
        w_win_min    = (r_min_lz < r_s1_lz) ? r_min_lz : r_s1_lz;
        w_decay_tgt  = f_clampd(w_win_min);
        w_attack     = (w_attack_amt < distance);
        // Decay uses the whole window's minimum, including the closing sample.
        w_decay      = w_win_end && !hold && !w_attack && (w_decay_tgt > distance)
                       && (distance < DISTW'(MAX_DIST));
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_s1_data      <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_lz        <= '0;
            DATA_OUT       <= '0;
            DATA_VALID_OUT <= 1'b0;
            distance       <= '0;
            r_win_cnt      <= '0;
            r_min_lz       <= LZ_MAX;
        end else begin
            r_s1_valid     <= DATA_VALID;
            DATA_VALID_OUT <= r_s1_valid;
            if (DATA_VALID) begin
                r_s1_data <= DATA_IN;
                r_s1_lz   <= f_lz(DATA_IN);
            end
            if (r_s1_valid) begin
                DATA_OUT <= r_s1_data;
                if (w_attack) begin
                    distance <= w_attack_amt;
                end else if (w_decay) begin
                    distance <= distance + DISTW'(1);
                end
                r_win_cnt <= r_win_cnt + WINDOW_LOG2'(1);
                r_min_lz  <= w_win_end ? LZ_MAX : w_win_min;
            end
        end
    end

endmodule

// File: doc/dac_auto_scaler.md
DAC_AUTO_SCALER -- requirements
Module: dac_auto_scaler

Interface
REQ-001 SHALL provide parameter WINDOW_LOG2, default 12, meaning the decay window is 2^WINDOW_LOG2 valid samples.
REQ-002 SHALL provide parameter MAX_DIST, default 14, meaning the upper clamp for distance.
REQ-003 SHALL provide parameter HEADROOM, default 1, meaning the number of spare sign bits always reserved.
REQ-004 SHALL have port clk_in  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-006 SHALL have port DATA_IN  input  28 signed  meaning the TX baseband sample.
REQ-007 SHALL have port DATA_VALID  input  1  meaning DATA_IN is valid this cycle.
REQ-008 SHALL have port hold  input  1  meaning decay is frozen while high; attack is unaffected.
REQ-009 SHALL have port DATA_OUT  output  28 signed  meaning DATA_IN delayed and aligned with distance.
REQ-010 SHALL have port DATA_VALID_OUT  output  1  meaning DATA_OUT is valid this cycle.
REQ-011 SHALL have port distance  output  8 unsigned  meaning the left-shift amount for the downstream DAC corrector.

Function
REQ-012 SHALL define lz(x) as the count of consecutive bits from bit 26 downward that equal bit 27, range 0..27; examples: lz(0)=27, lz(-1)=27, lz(-2^27)=0.
REQ-013 SHALL define clampd(v) as max(v-HEADROOM,0), then min with MAX_DIST.
REQ-014 SHALL use stage 1 to register DATA_IN, DATA_VALID and lz(DATA_IN) on every cycle.
REQ-015 SHALL use stage 2 to register DATA_OUT and DATA_VALID_OUT from stage 1 and to update distance in the same edge, giving a fixed 2-cycle latency.
REQ-016 SHALL never let a DATA_OUT sample appear with a distance greater than its lz-HEADROOM (floored at 0), so a left shift by distance cannot overflow 28 bits.
REQ-017 SHALL apply the attack rule on each valid stage-1 sample: if a=clampd(lz) < distance, then distance <= a, in the same edge that presents that sample on DATA_OUT.
REQ-018 SHALL keep a window counter of WINDOW_LOG2 bits that increments only on valid stage-1 samples and wraps from 2^WINDOW_LOG2-1 to 0.
REQ-019 SHALL keep a min-lz register, reset value 27, that tracks the minimum lz of valid samples in the current window.
REQ-020 SHALL define window end as a valid stage-1 sample with counter = 2^WINDOW_LOG2-1; at window end, m = min(minlz, current lz), and min-lz reloads to 27.
REQ-021 SHALL apply the decay rule at window end: if the attack rule did not fire, hold=0 and clampd(m) > distance, then distance <= distance+1 (one step per window only).
REQ-022 SHALL give attack priority when attack and window end coincide; the window still ends (min-lz reloads, counter wraps).
REQ-023 SHALL let the window counter and min-lz run normally while hold=1; only the decay step is suppressed.
REQ-024 SHALL leave all state unchanged on cycles with DATA_VALID low, except the pipeline valid bits, which propagate.
REQ-025 SHALL saturate distance at MAX_DIST and never let it go below 0.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set DATA_OUT=0, DATA_VALID_OUT=0, distance=0, stage-1 registers=0, window counter=0 and min-lz=27.
REQ-027 SHALL give reset priority over all other activity, including mid-window; the first valid sample after reset starts window position 0.

Verification (WINDOW_LOG2=4, MAX_DIST=14, HEADROOM=1)
REQ-028 SHALL verify reset: assert reset for 2 cycles with DATA_IN=0x7FFFFFF valid -> DATA_OUT=0, DATA_VALID_OUT=0, distance=0 on the cycle after release.
REQ-029 SHALL verify decay: constant DATA_IN=256 (lz=18) valid every cycle -> distance rises by 1 each 16 samples, reaches 14 after 14 windows, then stays at 14.
REQ-030 SHALL verify attack: at distance=14, one sample 0x0100000 (lz=6) -> distance=5 on the same edge that this sample appears on DATA_OUT (2 cycles after input); the preceding DATA_OUT still shows distance=14.
REQ-031 SHALL verify the extreme input: DATA_IN=0x8000000 -> distance=0 aligned with that sample; a following window of zeros -> distance=1 at that window end.
REQ-032 SHALL verify hold: hold=1 for 3 windows of zeros at distance=4 -> distance stays 4; an attack sample with lz=2 during hold -> distance=1.
REQ-033 SHALL verify gaps and reset: DATA_VALID toggling 1/0 -> window end after exactly 16 valid samples and DATA_VALID_OUT mirrors input 2 cycles later; reset at valid sample 7 -> next window end after 16 further valid samples.
